// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release controller.
// Holds every subsystem in reset until the PLL reports lock, then releases
// the stage resets one at a time, bit 0 first, with a fixed spacing. A new
// reset request or a loss of lock re-asserts every stage at once and the
// sequence starts again from bit 0. A lock timeout raises a sticky error flag
// without stopping the wait.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES      = 4,
    parameter int unsigned STAGE_DELAY_CC  = 1000,
    parameter int unsigned LOCK_TIMEOUT_CC = 100000
) (
    input  logic                  piul1Clock,
    input  logic                  piul1Reset,
    input  logic                  piul1ResetIn,
    input  logic                  piul1PllLocked,
    output logic [NUM_STAGES-1:0] poulvResetOut,
    output logic                  poul1Ready,
    output logic                  poul1LockError
);

    localparam int unsigned MAX_CC = (STAGE_DELAY_CC > LOCK_TIMEOUT_CC) ?
                                     STAGE_DELAY_CC : LOCK_TIMEOUT_CC;
    localparam int unsigned CNT_W  = $clog2(MAX_CC + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_STAGES) + 1;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY_CC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT_CC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        StHold,
        StWaitLock,
        StStage,
        StDone
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    lock_meta_q;
    logic                    lock_sync_q;
    logic [NUM_STAGES-1:0]   reset_out_q;
    logic                    ready_q;
    logic                    lock_error_q;

    logic                    running;

    // Lock loss only matters once clocks were already judged stable.
    assign running = (state_q == StStage) || (state_q == StDone);

    // Lock synchroniser, sequencing FSM and registered outputs.
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            idx_q        <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            reset_out_q  <= '1;
            ready_q      <= 1'b0;
            lock_error_q <= 1'b0;
        end else begin
            lock_meta_q <= piul1PllLocked;
            lock_sync_q <= lock_meta_q;

            if (state_q != StHold && piul1ResetIn) begin
                state_q     <= StHold;
                reset_out_q <= '1;
                ready_q     <= 1'b0;
                cnt_q       <= '0;
                idx_q       <= '0;
            end else if (running && !lock_sync_q) begin
                state_q     <= StWaitLock;
                reset_out_q <= '1;
                ready_q     <= 1'b0;
                cnt_q       <= '0;
                idx_q       <= '0;
            end else begin
                case (state_q)
                    StHold: begin
                        reset_out_q <= '1;
                        ready_q     <= 1'b0;
                        if (!piul1ResetIn) begin
                            state_q <= StWaitLock;
                            cnt_q   <= '0;
                        end
                    end
                    StWaitLock: begin
                        if (lock_sync_q) begin
                            state_q <= StStage;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else if (cnt_q == LOCK_LAST) begin
                            // Flag the timeout but keep waiting for lock.
                            lock_error_q <= 1'b1;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StStage: begin
                        if (cnt_q == STAGE_LAST) begin
                            // Stages fall strictly in order, so clearing bit idx_q
                            // is the same as shifting a zero in from the bottom.
                            reset_out_q <= reset_out_q << 1;
                            cnt_q       <= '0;
                            if (idx_q == IDX_LAST) begin
                                state_q <= StDone;
                                ready_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StDone: begin
                        state_q <= StDone;
                    end
                    default: begin
                        state_q     <= StHold;
                        reset_out_q <= '1;
                        ready_q     <= 1'b0;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                    end
                endcase
            end
        end
    end

    assign poulvResetOut  = reset_out_q;
    assign poul1Ready     = ready_q;
    assign poul1LockError = lock_error_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller that sits directly downstream of the debounced reset synchroniser. It takes the clean, clock-synchronous system reset request and the PLL lock indication, and de-asserts a vector of per-subsystem resets one at a time, e.g. clocking, sensor interface, pixel pipeline, then host bus. It holds the camera datapath in reset until clocks are stable, and re-sequences automatically on a new reset request or on loss of lock.

## Interface
- NUM_STAGES, 4: number of reset outputs; legal range 1..16.
- STAGE_DELAY_CC, 1000: cycles between consecutive stage releases; ≥1.
- LOCK_TIMEOUT_CC, 100000: cycles waited for lock before flagging an error; ≥1.

- piul1Clock  in  1  system clock. One clock domain; there are no other clocks.
- piul1Reset  in  1  reset, asynchronous and active-high.
- piul1ResetIn  in  1  synchronous reset request from the upstream synchroniser; 1 = hold the system in reset.
- piul1PllLocked  in  1  PLL lock, asynchronous to piul1Clock; passed through a 2-flop synchroniser internally (lockSync).
- poulvResetOut  out  NUM_STAGES  active-high stage resets; bit 0 is released first, bit NUM_STAGES-1 last.
- poul1Ready  out  1  high when all stages are released.
- poul1LockError  out  1  sticky; set on lock timeout, cleared only by piul1Reset.

## Operation
- FSM states: HOLD, WAIT_LOCK, STAGE, DONE.
- Internal registers: cycle counter, width $clog2(max(STAGE_DELAY_CC, LOCK_TIMEOUT_CC)+1); stage index, width $clog2(NUM_STAGES)+1.
- piul1Reset asserted: state HOLD, poulvResetOut all ones, poul1Ready 0, poul1LockError 0, counter 0, index 0, synchroniser flops 0.
- HOLD:
  - All reset bits are 1.
  - piul1ResetIn==0 → WAIT_LOCK, counter 0.
- WAIT_LOCK:
  - lockSync==1 → STAGE, counter 0, index 0.
  - Otherwise counter increments.
  - When counter==LOCK_TIMEOUT_CC-1: poul1LockError←1, counter←0, stay in WAIT_LOCK and keep waiting (no abort).
- STAGE:
  - Counter increments.
  - When counter==STAGE_DELAY_CC-1: poulvResetOut[index]←0, counter←0.
  - If index==NUM_STAGES-1: →DONE and poul1Ready←1 on the same edge. Otherwise index increments.
- DONE: holds all outputs.
- Priority, evaluated every edge in every state except HOLD:
  1. piul1ResetIn==1 → HOLD, all reset bits 1, poul1Ready 0, counter 0, index 0.
  2. In STAGE or DONE only, lockSync==0 → WAIT_LOCK, all reset bits 1, poul1Ready 0, counter 0, index 0.
  3. Normal transition.
- Resets are released strictly in order and never re-asserted individually; any re-assert asserts all bits at once.
- poul1LockError does not influence sequencing.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- piul1PllLocked to lockSync latency: 2 edges.
- Release schedule, with lockSync already 1 and piul1ResetIn first sampled 0 at edge E0:
  - WAIT_LOCK entered at E0, STAGE entered at E0+1.
  - Bit k falls at E0+1+(k+1)·STAGE_DELAY_CC.
  - poul1Ready rises with the last bit.
- Re-assert latency:
  - piul1ResetIn high: 1 edge.
  - piul1PllLocked low: 3 edges.
- Lock timeout: first poul1LockError at edge E0+LOCK_TIMEOUT_CC, then the counter re-arms.
- Asynchronous reset mid-sequence: outputs reach their reset values immediately, without a clock edge.

## Test plan
Bench parameters: NUM_STAGES=3, STAGE_DELAY_CC=4, LOCK_TIMEOUT_CC=20.
1. piul1PllLocked held 1, piul1ResetIn falls at E0 → poulvResetOut 3'b111→3'b110 at E5, 3'b100 at E9, 3'b000 at E13; poul1Ready 1 at E13.
2. piul1PllLocked held 0, piul1ResetIn falls at E0 → poul1LockError 1 at E20, outputs stay 3'b111; lock rises later → normal sequence; poul1LockError remains 1.
3. In DONE, piul1PllLocked drops at edge D → poulvResetOut 3'b111 and poul1Ready 0 at D+3; lock restored → full re-sequence with the 4-cycle spacing.
4. piul1ResetIn rises one edge after bit 0 releases → 3'b111 next edge, HOLD; no release while piul1ResetIn stays high; sequence restarts from bit 0 on its fall.
5. piul1Reset pulsed asynchronously in DONE with poul1LockError set → 3'b111, poul1Ready 0, poul1LockError 0 without a clock edge.
6. NUM_STAGES=1, STAGE_DELAY_CC=1, lock held 1 → bit 0 and poul1Ready change at E2.
